// File: rtl/vga_buf_pkg.sv
// Shared types and constants for the SDRAM-to-VGA read buffer: controller
// states, pixel width and the default 640x480 frame geometry.
package vga_buf_pkg;

  localparam int PIX_W           = 16;  // RGB565
  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_HOLD,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, synchronous flush and an
// occupancy output. A read while empty returns zero.
module sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (level == '0);
  assign do_wr = wr_en && !flush && (level != LW'(DEPTH));
  assign do_rd = rd_en && !flush && !empty;

  // NOTE: storage has no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (rd_en) rd_data <= empty ? '0 : mem[rd_ptr];
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_vga_rd_buf.sv
// Prefetches one frame from SDRAM in fixed bursts into a FIFO and hands one
// pixel per display request; rewinds to the frame base on vga_done.
module sdram_vga_rd_buf
  import vga_buf_pkg::*;
#(
  parameter int FIFO_DEPTH  = 512,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 22
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vga_display_value,
  output logic [PIX_W-1:0]              rd_q,
  input  logic                          vga_done,
  output logic                          sd_rd_req,
  output logic [ADDR_W-1:0]             sd_rd_addr,
  input  logic                          sd_rd_ack,
  input  logic                          sd_rd_valid,
  input  logic [PIX_W-1:0]              sd_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int                BW         = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BURST_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [BW-1:0]     beat_cnt;
  logic              room;
  logic              last_beat;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_flush;
  logic              fifo_empty;

  assign ptr_inc    = ptr + BURST_STEP;
  assign last_beat  = sd_rd_valid && (beat_cnt == LAST_BEAT);
  assign sd_rd_addr = ptr;
  // Space for a whole burst is reserved before requesting, so writes never overflow.
  assign room = (32'(fifo_level) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!vga_done && room && (ptr < FRAME_END)) state_nxt = ST_REQ;
      ST_REQ: begin
        if (sd_rd_ack)     state_nxt = vga_done ? ST_FLUSH : ST_DATA;
        else if (vga_done) state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (last_beat)     state_nxt = (!vga_done && ptr_inc == FRAME_END) ? ST_HOLD : ST_IDLE;
        else if (vga_done) state_nxt = ST_FLUSH;
      end
      ST_HOLD:  if (vga_done)  state_nxt = ST_IDLE;
      ST_FLUSH: if (last_beat) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_req  = (state == ST_REQ);
    fifo_wr    = (state == ST_DATA) && sd_rd_valid;
    // An in-flight burst must drain before the rewind; otherwise rewind at once.
    fifo_flush = (vga_done && (state == ST_IDLE || state == ST_HOLD ||
                               (state == ST_REQ && !sd_rd_ack))) ||
                 (last_beat && (state == ST_FLUSH || (state == ST_DATA && vga_done)));
    fifo_rd    = vga_display_value && !vga_done && !fifo_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      beat_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      if (fifo_flush)                         ptr <= '0;
      else if (state == ST_DATA && last_beat) ptr <= ptr_inc;

      if (state == ST_REQ && sd_rd_ack)
        beat_cnt <= '0;
      else if ((state == ST_DATA || state == ST_FLUSH) && sd_rd_valid)
        beat_cnt <= beat_cnt + BW'(1);

      if (vga_done)                    underflow <= 1'b0;
      else if (fifo_rd && fifo_empty)  underflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (sd_rd_data),
    .rd_en   (fifo_rd),
    .rd_data (rd_q),
    .level   (fifo_level),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_vga_rd_buf.sv
// Bench for sdram_vga_rd_buf: a reset/underflow vector table, then directed
// sequences against a simple SDRAM burst model for the multi-cycle cases.
module tb_sdram_vga_rd_buf;

  localparam int FIFO_DEPTH  = 512;
  localparam int BURST_LEN   = 256;
  localparam int FRAME_WORDS = 1024;
  localparam int ADDR_W      = 22;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              vga_display_value;
  logic [15:0]       rd_q;
  logic              vga_done;
  logic              sd_rd_req;
  logic [ADDR_W-1:0] sd_rd_addr;
  logic              sd_rd_ack;
  logic              sd_rd_valid;
  logic [15:0]       sd_rd_data;
  logic [LW-1:0]     fifo_level;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // SDRAM model controls and observations
  bit                mdl_en     = 0;
  int                ack_dly    = 2;
  int                gap        = 0;
  int                beats_sent = 0;
  int                req_cnt    = 0;
  logic [ADDR_W-1:0] req_addr [$];

  sdram_vga_rd_buf #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .vga_display_value (vga_display_value),
    .rd_q              (rd_q),
    .vga_done          (vga_done),
    .sd_rd_req         (sd_rd_req),
    .sd_rd_addr        (sd_rd_addr),
    .sd_rd_ack         (sd_rd_ack),
    .sd_rd_valid       (sd_rd_valid),
    .sd_rd_data        (sd_rd_data),
    .fifo_level        (fifo_level),
    .underflow         (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One burst: ack after ack_dly cycles, then BURST_LEN beats of address-index data.
  task automatic serve_burst();
    logic [ADDR_W-1:0] a;
    bit abort;
    a = sd_rd_addr;
    abort = 0;
    req_addr.push_back(a);
    req_cnt++;
    for (int d = 0; d < ack_dly && !abort; d++) begin
      @(negedge clk);
      if (!rst_n || !sd_rd_req) abort = 1;
    end
    if (!abort) begin
      sd_rd_ack = 1'b1;
      @(negedge clk);
      sd_rd_ack = 1'b0;
      for (int k = 0; k < BURST_LEN && rst_n; k++) begin
        sd_rd_valid = 1'b1;
        sd_rd_data  = 16'(a) + 16'(k);
        @(negedge clk);
        sd_rd_valid = 1'b0;
        beats_sent++;
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
    end
  endtask

  initial begin
    sd_rd_ack   = 1'b0;
    sd_rd_valid = 1'b0;
    sd_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (mdl_en && rst_n && sd_rd_req) serve_burst();
    end
  end

  // Pop n words (only when the FIFO reports data) and check each against first+i.
  task automatic pop_words(input int n, input int first);
    int issued;
    bit pend;
    issued = 0;
    pend   = 0;
    while (issued < n || pend) begin
      if (pend) check("rd_q", 32'(rd_q), 32'(16'(first + issued - 1)));
      if (issued < n && fifo_level != '0) begin
        vga_display_value = 1'b1;
        issued++;
        pend = 1;
      end else begin
        vga_display_value = 1'b0;
        pend = 0;
      end
      @(negedge clk);
    end
    vga_display_value = 1'b0;
  endtask

  task automatic pulse_done();
    vga_done = 1'b1;
    @(negedge clk);
    vga_done = 1'b0;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  typedef struct {
    logic          disp;
    logic          done;
    logic [15:0]   exp_q;
    logic          exp_uf;
    logic [LW-1:0] exp_lvl;
    logic          exp_req;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Empty FIFO, SDRAM silent: request held, underflow set/cleared, done-vs-pop priority.
    vecs[0] = '{1'b0, 1'b0, 16'h0, 1'b0, LW'(0), 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'h0, 1'b1, LW'(0), 1'b1};
    vecs[2] = '{1'b0, 1'b0, 16'h0, 1'b1, LW'(0), 1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'h0, 1'b0, LW'(0), 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0, 1'b0, LW'(0), 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h0, 1'b0, LW'(0), 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0, 1'b1, LW'(0), 1'b1};
    vecs[7] = '{1'b0, 1'b0, 16'h0, 1'b1, LW'(0), 1'b1};

    rst_n = 1'b0;
    vga_display_value = 1'b0;
    vga_done = 1'b0;
    #3;
    check("rst_rd_q",      32'(rd_q),       32'd0);
    check("rst_req",       32'(sd_rd_req),  32'd0);
    check("rst_addr",      32'(sd_rd_addr), 32'd0);
    check("rst_level",     32'(fifo_level), 32'd0);
    check("rst_underflow", 32'(underflow),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      vga_display_value = vecs[i].disp;
      vga_done          = vecs[i].done;
      @(negedge clk);
      check($sformatf("vec%0d_rd_q", i),  32'(rd_q),       32'(vecs[i].exp_q));
      check($sformatf("vec%0d_uf", i),    32'(underflow),  32'(vecs[i].exp_uf));
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_req", i),   32'(sd_rd_req),  32'(vecs[i].exp_req));
      check($sformatf("vec%0d_addr", i),  32'(sd_rd_addr), 32'd0);
    end
    vga_display_value = 1'b0;
    vga_done = 1'b0;

    // Cold start: two bursts fill the FIFO, third waits for 256 pops.
    rst_n = 1'b0;
    @(negedge clk);
    req_addr.delete();
    req_cnt = 0;
    beats_sent = 0;
    mdl_en = 1;
    ack_dly = 2;
    gap = 0;
    rst_n = 1'b1;
    wait (beats_sent == 512);
    repeat (3) @(negedge clk);
    check("cold_level",    32'(fifo_level), 32'd512);
    check("cold_req_cnt",  32'(req_cnt),    32'd2);
    check("cold_addr0",    32'(req_addr[0]), 32'd0);
    check("cold_addr1",    32'(req_addr[1]), 32'd256);
    repeat (40) @(negedge clk);
    check("cold_no_third", 32'(req_cnt),    32'd2);
    pop_words(255, 0);
    check("cold_level_257", 32'(fifo_level), 32'd257);
    repeat (20) @(negedge clk);
    check("cold_still_two", 32'(req_cnt),   32'd2);
    check("cold_req_low",   32'(sd_rd_req), 32'd0);
    ack_dly = 20;
    pop_words(1, 255);
    wait (req_cnt == 3);
    check("third_addr", 32'(req_addr[2]), 32'd512);
    repeat (2) @(negedge clk);
    check("third_req_high", 32'(sd_rd_req), 32'd1);

    // Async reset while the request is pending: outputs clear before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   32'(sd_rd_req),  32'd0);
    check("arst_addr",  32'(sd_rd_addr), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_rd_q",  32'(rd_q),       32'd0);
    check("arst_uf",    32'(underflow),  32'd0);
    repeat (3) @(negedge clk);

    // Steady readout with slow SDRAM, then the rest of the frame and HOLD.
    req_addr.delete();
    req_cnt = 0;
    beats_sent = 0;
    ack_dly = 10;
    gap = 1;
    rst_n = 1'b1;
    pop_words(640, 0);
    check("steady_uf", 32'(underflow), 32'd0);
    pop_words(384, 640);
    repeat (50) @(negedge clk);
    check("frame_req_cnt", 32'(req_cnt),     32'd4);
    check("frame_addr2",   32'(req_addr[2]), 32'd512);
    check("frame_addr3",   32'(req_addr[3]), 32'd768);
    check("hold_req_low",  32'(sd_rd_req),   32'd0);
    check("hold_level",    32'(fifo_level),  32'd0);
    check("hold_uf",       32'(underflow),   32'd0);
    beats_sent = 0;
    pulse_done();
    wait (req_cnt == 5);
    check("rewind_addr", 32'(req_addr[4]), 32'd0);

    // vga_done after beat 100: the rest of the burst is discarded, then rewind.
    wait (beats_sent == 100);
    vga_done = 1'b1;
    @(negedge clk);
    vga_done = 1'b0;
    check("flush_level_100", 32'(fifo_level), 32'd100);
    check("flush_req_low",   32'(sd_rd_req),  32'd0);
    wait (beats_sent == 200);
    check("flush_discard", 32'(fifo_level), 32'd100);
    wait (beats_sent == 256);
    check("flush_level_0", 32'(fifo_level), 32'd0);
    wait (req_cnt == 6);
    check("flush_rewind_addr", 32'(req_addr[5]), 32'd0);
    pop_words(2, 0);
    check("flush_uf", 32'(underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
